// File: rtl/step_dir_generator.sv
// step_dir_generator: accepts move commands and drives the step/dir pulse
// stream into the microstepper phase counter while tracking net position.
// Pulse width, dir-to-step setup and step period are latched per move.
module step_dir_generator #(
    parameter int CNT_W = 32,
    parameter int PER_W = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CNT_W-1:0] cmd_steps,
    input  logic             cmd_dir,
    input  logic [PER_W-1:0] cmd_period,
    input  logic [7:0]       config_pulse_width,
    input  logic [7:0]       config_dir_setup,
    input  logic             abort,
    output logic             step,
    output logic             dir,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [CNT_W-1:0] steps_remaining,
    output logic [CNT_W-1:0] position
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        HIGH,
        LOW
    } state_t;

    localparam logic [PER_W-1:0] PER_ONE = PER_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state;
    logic [PER_W-1:0] timer;       // cycles left in the current state, minus one
    logic [PER_W-1:0] pw_q;        // latched effective pulse width
    logic [PER_W-1:0] lt_q;        // latched effective low time
    logic             abort_pend;  // abort seen during a pulse, honoured at its end

    logic [PER_W-1:0] pw_eff;
    logic [PER_W-1:0] per_eff;
    logic [PER_W-1:0] lt_eff;
    logic [CNT_W-1:0] pos_cmd_step;
    logic [CNT_W-1:0] pos_step;

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    // Effective timing from the offered command: pulse width at least one
    // cycle, period long enough to leave at least one low cycle.
    always_comb begin
        pw_eff  = (config_pulse_width == 8'd0) ? PER_ONE : PER_W'(config_pulse_width);
        per_eff = (cmd_period > pw_eff) ? cmd_period : pw_eff + PER_ONE;
        lt_eff  = per_eff - pw_eff;
    end

    // Position after one step: first step of a move uses the incoming
    // direction, later steps use the registered one.
    always_comb begin
        pos_cmd_step = cmd_dir ? position + CNT_ONE : position - CNT_ONE;
        pos_step     = dir     ? position + CNT_ONE : position - CNT_ONE;
    end

    // Move sequencer: command accept, setup delay, pulse high/low timing,
    // abort handling and position/remaining bookkeeping.
    // NOTE: every register here, including the latched timing values, is
    // cleared by the asynchronous reset so a reset mid-move leaves no stale
    // state behind; all updates are non-blocking so the whole block sees
    // the pre-edge values of state, timer and position.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state           <= IDLE;
            timer           <= '0;
            pw_q            <= PER_ONE;
            lt_q            <= PER_ONE;
            abort_pend      <= 1'b0;
            step            <= 1'b0;
            dir             <= 1'b0;
            done            <= 1'b0;
            aborted         <= 1'b0;
            steps_remaining <= '0;
            position        <= '0;
        end else begin
            done    <= 1'b0;
            aborted <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        dir        <= cmd_dir;
                        pw_q       <= pw_eff;
                        lt_q       <= lt_eff;
                        abort_pend <= 1'b0;
                        if (cmd_steps == '0) begin
                            steps_remaining <= '0;
                            done            <= 1'b1;
                        end else if (config_dir_setup == 8'd0) begin
                            state           <= HIGH;
                            step            <= 1'b1;
                            timer           <= pw_eff - PER_ONE;
                            steps_remaining <= cmd_steps - CNT_ONE;
                            position        <= pos_cmd_step;
                        end else begin
                            state           <= SETUP;
                            timer           <= PER_W'(config_dir_setup) - PER_ONE;
                            steps_remaining <= cmd_steps;
                        end
                    end
                end

                SETUP: begin
                    if (abort) begin
                        state   <= IDLE;
                        aborted <= 1'b1;
                    end else if (timer == '0) begin
                        state           <= HIGH;
                        step            <= 1'b1;
                        timer           <= pw_q - PER_ONE;
                        steps_remaining <= steps_remaining - CNT_ONE;
                        position        <= pos_step;
                    end else begin
                        timer <= timer - PER_ONE;
                    end
                end

                HIGH: begin
                    // A pulse is never truncated: abort only takes effect
                    // once the full high time has elapsed.
                    if (timer == '0) begin
                        step <= 1'b0;
                        if (abort || abort_pend) begin
                            state   <= IDLE;
                            aborted <= 1'b1;
                        end else begin
                            state <= LOW;
                            timer <= lt_q - PER_ONE;
                        end
                    end else begin
                        timer <= timer - PER_ONE;
                        if (abort) begin
                            abort_pend <= 1'b1;
                        end
                    end
                end

                LOW: begin
                    if (abort) begin
                        state   <= IDLE;
                        aborted <= 1'b1;
                    end else if (timer == '0) begin
                        if (steps_remaining != '0) begin
                            state           <= HIGH;
                            step            <= 1'b1;
                            timer           <= pw_q - PER_ONE;
                            steps_remaining <= steps_remaining - CNT_ONE;
                            position        <= pos_step;
                        end else begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end
                    end else begin
                        timer <= timer - PER_ONE;
                    end
                end

                default: begin
                    state <= IDLE;
                    step  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_step_dir_generator.sv
// Testbench for step_dir_generator: each move is predicted cycle by cycle
// from the timing rules (rise every PER cycles after the setup delay, high
// for PW, completion one PER after the last rise) and compared per cycle.
module tb_step_dir_generator;

    localparam int CNT_W = 32;
    localparam int PER_W = 16;

    logic             clk;
    logic             resetn;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [CNT_W-1:0] cmd_steps;
    logic             cmd_dir;
    logic [PER_W-1:0] cmd_period;
    logic [7:0]       config_pulse_width;
    logic [7:0]       config_dir_setup;
    logic             abort;
    logic             step;
    logic             dir;
    logic             busy;
    logic             done;
    logic             aborted;
    logic [CNT_W-1:0] steps_remaining;
    logic [CNT_W-1:0] position;

    int               n_checks;
    int               n_fail;
    logic [CNT_W-1:0] exp_pos;

    step_dir_generator #(
        .CNT_W(CNT_W),
        .PER_W(PER_W)
    ) dut (
        .clk               (clk),
        .resetn            (resetn),
        .cmd_valid         (cmd_valid),
        .cmd_ready         (cmd_ready),
        .cmd_steps         (cmd_steps),
        .cmd_dir           (cmd_dir),
        .cmd_period        (cmd_period),
        .config_pulse_width(config_pulse_width),
        .config_dir_setup  (config_dir_setup),
        .abort             (abort),
        .step              (step),
        .dir               (dir),
        .busy              (busy),
        .done              (done),
        .aborted           (aborted),
        .steps_remaining   (steps_remaining),
        .position          (position)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Runs one move starting at a negedge with the DUT idle, and checks every
    // cycle up to and including the completion cycle. abort_at is the cycle
    // (1 = first cycle after accept) during which abort is held high; 0 means
    // no abort, -1 picks one at random (or none).
    task automatic run_move(input string name, input int steps, input bit d,
                            input int period, input int pw_cfg, input int setup,
                            input int abort_at);
        int pw, per, first, normal_end, end_k, issued, rel, idx, ph, ab_k;
        bit ab;
        logic [CNT_W-1:0] pos0, e_pos, e_rem;
        logic e_step, e_busy, e_done, e_ab, e_ready;
        logic [CNT_W+CNT_W+5:0] got, want;

        pw         = (pw_cfg == 0) ? 1 : pw_cfg;
        per        = (period > pw) ? period : pw + 1;
        first      = 1 + setup;
        normal_end = first + steps * per;
        ab_k       = abort_at;
        if (ab_k < 0) begin
            ab_k = (steps > 0 && $urandom_range(0, 2) == 0) ? $urandom_range(1, normal_end - 1) : 0;
        end
        if (steps == 0) ab_k = 0;
        pos0 = exp_pos;

        if (steps == 0) begin
            end_k = 1; issued = 0; ab = 1'b0;
        end else if (ab_k == 0) begin
            end_k = normal_end; issued = steps; ab = 1'b0;
        end else if (ab_k < first) begin
            end_k = ab_k + 1; issued = 0; ab = 1'b1;
        end else begin
            rel = ab_k - first; idx = rel / per; ph = rel % per;
            issued = idx + 1; ab = 1'b1;
            end_k = (ph < pw) ? first + idx * per + pw : ab_k + 1;
        end

        n_checks++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s ready_before_accept: got %b expected 1", name, cmd_ready);
        end

        cmd_valid          = 1'b1;
        cmd_steps          = CNT_W'(steps);
        cmd_dir            = d;
        cmd_period         = PER_W'(period);
        config_pulse_width = 8'(pw_cfg);
        config_dir_setup   = 8'(setup);
        @(posedge clk);
        #1;
        // Scramble command/config inputs: the move must use latched values.
        cmd_valid          = 1'b0;
        cmd_steps          = CNT_W'($urandom);
        cmd_dir            = 1'($urandom);
        cmd_period         = PER_W'($urandom_range(0, 30));
        config_pulse_width = 8'($urandom_range(0, 9));
        config_dir_setup   = 8'($urandom_range(0, 9));

        for (int k = 1; k <= end_k; k++) begin
            @(negedge clk);
            if (k == end_k) begin
                e_step = 0; e_busy = 0; e_ready = 1; e_done = !ab; e_ab = ab;
                e_rem  = CNT_W'(steps - issued);
                e_pos  = d ? pos0 + CNT_W'(issued) : pos0 - CNT_W'(issued);
            end else if (k < first) begin
                e_step = 0; e_busy = 1; e_ready = 0; e_done = 0; e_ab = 0;
                e_rem  = CNT_W'(steps);
                e_pos  = pos0;
            end else begin
                rel = k - first; idx = rel / per; ph = rel % per;
                e_step = (ph < pw); e_busy = 1; e_ready = 0; e_done = 0; e_ab = 0;
                e_rem  = CNT_W'(steps - idx - 1);
                e_pos  = d ? pos0 + CNT_W'(idx + 1) : pos0 - CNT_W'(idx + 1);
            end
            got  = {step, dir, busy, done, aborted, cmd_ready, steps_remaining, position};
            want = {e_step, d, e_busy, e_done, e_ab, e_ready, e_rem, e_pos};
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL %s cycle %0d: got step/dir/busy/done/aborted/ready=%b rem=%0d pos=%h, expected %b rem=%0d pos=%h",
                         name, k, got[CNT_W+CNT_W+5:CNT_W+CNT_W], steps_remaining, position,
                         want[CNT_W+CNT_W+5:CNT_W+CNT_W], e_rem, e_pos);
            end
            abort = (k == ab_k);
        end
        abort   = 1'b0;
        exp_pos = d ? pos0 + CNT_W'(issued) : pos0 - CNT_W'(issued);
    endtask

    task automatic test_reset();
        resetn             = 1'b0;
        cmd_valid          = 1'b1;
        cmd_steps          = CNT_W'(7);
        cmd_dir            = 1'b1;
        cmd_period         = PER_W'(5);
        config_pulse_width = 8'd2;
        config_dir_setup   = 8'd0;
        abort              = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({step, dir, busy, done, aborted, cmd_ready} !== 6'b000001 ||
            steps_remaining !== '0 || position !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got flags=%b rem=%0d pos=%h expected 000001 rem=0 pos=0",
                     {step, dir, busy, done, aborted, cmd_ready}, steps_remaining, position);
        end
        cmd_valid = 1'b0;
        resetn    = 1'b1;
        exp_pos   = '0;
        @(negedge clk);
        n_checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: got ready=%b busy=%b expected ready=1 busy=0", cmd_ready, busy);
        end
    endtask

    task automatic test_basic();
        run_move("fwd_setup", 3, 1'b1, 10, 2, 4, 0);
        run_move("rev_nosetup", 2, 1'b0, 4, 1, 0, 0);
    endtask

    task automatic test_clamp();
        run_move("clamp_per", 3, 1'b1, 2, 5, 1, 0);
        run_move("pw_zero", 3, 1'b0, 3, 0, 2, 0);
    endtask

    task automatic test_zero_steps();
        run_move("zero_steps", 0, 1'b1, 7, 3, 2, 0);
    endtask

    task automatic test_abort();
        // 2nd cycle of the 2nd pulse: first rise at 4, second at 16.
        run_move("abort_high", 5, 1'b1, 12, 4, 3, 17);
        run_move("abort_setup", 4, 1'b0, 8, 2, 5, 2);
        run_move("abort_low", 3, 1'b1, 9, 2, 1, 5);
        // Last LOW cycle of a 2-step move: aborted wins over done.
        run_move("abort_final_low", 2, 1'b1, 6, 2, 0, 12);
    endtask

    task automatic test_reset_mid_move();
        cmd_valid          = 1'b1;
        cmd_steps          = CNT_W'(4);
        cmd_dir            = 1'b1;
        cmd_period         = PER_W'(8);
        config_pulse_width = 8'd3;
        config_dir_setup   = 8'd0;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (step !== 1'b1 || dir !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset_prestate: got step=%b dir=%b expected step=1 dir=1", step, dir);
        end
        @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        n_checks++;
        if ({step, dir, busy, done, aborted, cmd_ready} !== 6'b000001 ||
            steps_remaining !== '0 || position !== '0) begin
            n_fail++;
            $display("FAIL mid_reset_async: got flags=%b rem=%0d pos=%h expected 000001 rem=0 pos=0",
                     {step, dir, busy, done, aborted, cmd_ready}, steps_remaining, position);
        end
        repeat (2) @(negedge clk);
        resetn  = 1'b1;
        exp_pos = '0;
        @(negedge clk);
        n_checks++;
        if (cmd_ready !== 1'b1 || step !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_release: got ready=%b step=%b expected ready=1 step=0", cmd_ready, step);
        end
        run_move("after_reset", 2, 1'b1, 5, 2, 1, 0);
    endtask

    task automatic test_wrap();
        // From position 2, five reverse steps wrap below zero.
        run_move("wrap_below_zero", 5, 1'b0, 3, 1, 0, 0);
        run_move("wrap_back_up", 4, 1'b1, 4, 2, 2, 0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 24; i++) begin
            run_move("random", $urandom_range(0, 5), 1'($urandom), $urandom_range(0, 20),
                     $urandom_range(0, 6), $urandom_range(0, 5), -1);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        exp_pos  = '0;
        test_reset();
        test_basic();
        test_clamp();
        test_zero_steps();
        test_abort();
        test_reset_mid_move();
        test_wrap();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
